prio_dispatch: RTL and testbench
================================

Name: prio_dispatch

Overview:
- Scheduler that shares one priority-select datapath between N interrupt/event requesters.
- Each requester owns a programmable priority register and a pending bit. The block selects the highest-priority pending requester and presents it as a grant, using a valid/ready handshake.
- Sits between the request sources and the consumer of the selected index, e.g. the core's dispatch or interrupt-entry logic.
- Configuration arrives on a simple single-cycle write port.

Parameters:
- N, 8, number of requesters; power of two, 2..32
- PRIO_W, 32, width of each priority value
- IDX_W, $clog2(N), width of requester index

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset; block is held in reset while low
- req  in  N  per-requester set pulse; bit i high for a cycle sets pending[i]
- cfg_we  in  1  priority write strobe
- cfg_idx  in  IDX_W  priority register to write
- cfg_prio  in  PRIO_W  priority value; 0 disables the requester
- pending  out  N  current pending bits
- grant_valid  out  1  grant offered
- grant_idx  out  IDX_W  granted requester index
- grant_prio  out  PRIO_W  priority of the granted requester, captured at select time
- grant_ready  in  1  consumer accepts the grant

Behaviour:
- Reset (async assert, sync release):
  - All priority registers 0; pending 0.
  - grant_valid 0, grant_idx 0, grant_prio 0.
  - FSM in IDLE.
- Priority write: on cfg_we, prio[cfg_idx] <= cfg_prio at the next edge. Writes are accepted in every state.
- Pending:
  - Set: pending[i] <= 1 when req[i] is high.
  - Clear: pending[grant_idx] is cleared on the handshake edge (grant_valid & grant_ready).
  - Set and clear of the same bit in the same cycle: set wins, bit stays 1.
- Eligibility: requester i is eligible iff pending[i]=1 and prio[i]!=0.
- Select function:
  - Combinational unsigned max over eligible priorities.
  - Tie goes to the lowest index.
  - Ineligible entries are treated as priority 0 and never win.
- FSM states IDLE, SELECT, GRANT:
  - IDLE: if any requester is eligible -> SELECT, else stay.
  - SELECT (one cycle): register winner index and priority into grant_idx/grant_prio. If nothing is eligible any more (cleared by a priority write) -> IDLE; else -> GRANT with grant_valid=1.
  - GRANT:
    - grant_valid, grant_idx and grant_prio are held stable until handshake. Later requests or priority writes do not change them; no preemption.
    - On grant_ready: grant_valid <= 0, clear pending per the rule above, -> IDLE.
- Latency:
  - req edge to grant_valid high = 3 cycles when idle: pending set, IDLE->SELECT, SELECT->GRANT.
  - Minimum spacing between successive grants = 3 cycles (GRANT->IDLE->SELECT->GRANT).
- grant_ready while grant_valid=0 is ignored.
- Priority write to the granted index during GRANT: grant_prio is unchanged; the new value applies at the next selection.
- Reset asserted mid-handshake: grant drops immediately (async) and all pending bits are lost.
- Index width: cfg_idx values >= N are ignored when N is not a power of two (not reachable for legal N).

Optional Feature:
- Macro: PRIO_DISPATCH_STATS_EN
- Defined:
  - Adds output grant_count (32 bits, reset 0), incremented on every handshake and wrapping from 0xFFFFFFFF to 0.
  - Adds output drop_count (16 bits, reset 0), incremented when a req bit arrives for a requester already pending and not being cleared that cycle; saturates at 0xFFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Priorities {7,4,3,7,5,6,7,8} for idx 0..7; pulse req=0xFF; hold grant_ready=1 -> grant_idx order 7,0,3,6,5,4,1,2; first grant_valid exactly 3 cycles after the req pulse.
- Priorities all 0; req=0xFF -> grant_valid stays 0 for 20 cycles, pending=0xFF. Then write prio[5]=1 -> grant_idx=5, grant_prio=1.
- During GRANT of idx 2 (prio 3), hold grant_ready=0 for 10 cycles, pulse req[7] with prio 8 -> grant_idx remains 2 until handshake; next grant is idx 7.
- Handshake on idx 4 in the same cycle req[4]=1 -> pending[4] stays 1 and idx 4 is granted again 3 cycles later.
- Write prio[3]=0 in the cycle IDLE->SELECT, with only idx 3 pending -> FSM returns to IDLE, grant_valid never asserts, pending[3] stays 1.
- Drive reset low while grant_valid=1 -> grant_valid, pending and grant_idx read 0 before the next clk edge. With PRIO_DISPATCH_STATS_EN, grant_count is 0 after reset and 8 after the first scenario.

Source files
------------

// File: rtl/prio_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : prio_dispatch
// Description : Shares one priority-select datapath between N requesters.
//               Each requester has a programmable priority and a pending bit;
//               the highest-priority eligible requester (ties to the lowest
//               index) is offered on a valid/ready grant port.
//               Optional macro PRIO_DISPATCH_STATS_EN adds grant_count and
//               drop_count statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_dispatch #(
    parameter int N      = 8,
    parameter int PRIO_W = 32,
    parameter int IDX_W  = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [PRIO_W-1:0] cfg_prio,
    output logic [N-1:0]      pending,
    output logic              grant_valid,
    output logic [IDX_W-1:0]  grant_idx,
    output logic [PRIO_W-1:0] grant_prio,
    input  logic              grant_ready
`ifdef PRIO_DISPATCH_STATS_EN
    ,
    output logic [31:0]       grant_count,
    output logic [15:0]       drop_count
`endif
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SELECT = 2'd1;
    localparam logic [1:0] c_GRANT  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [PRIO_W-1:0] r_prio [N];
    logic [N-1:0]      r_pending;
    logic [N-1:0]      w_elig;
    logic [N-1:0]      w_clr;
    logic              w_hs;
    logic              w_any;
    logic [IDX_W-1:0]  w_win_idx;
    logic [PRIO_W-1:0] w_win_prio;
    logic              r_grant_valid;
    logic [IDX_W-1:0]  r_grant_idx;
    logic [PRIO_W-1:0] r_grant_prio;

    assign w_hs        = r_grant_valid & grant_ready;
    assign pending     = r_pending;
    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;
    assign grant_prio  = r_grant_prio;

    // Per-requester priority register and eligibility; indices outside 0..N-1
    // never match, so out-of-range writes fall away naturally.
    for (genvar gi = 0; gi < N; gi++) begin : g_prio
        // Priority register write, accepted in every FSM state
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_prio[gi] <= '0;
            end else if (cfg_we && (cfg_idx == IDX_W'(gi))) begin
                r_prio[gi] <= cfg_prio;
            end
        end

        assign w_elig[gi] = r_pending[gi] && (r_prio[gi] != '0);
    end

    // One-hot clear mask for the granted requester on the handshake edge
    always_comb begin
        w_clr = '0;
        if (w_hs) begin
            w_clr[r_grant_idx] = 1'b1;
        end
    end

    // Pending bits: a new request wins over a simultaneous handshake clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | req;
        end
    end

    // Unsigned max over eligible priorities; strict compare keeps lowest index on ties
    always_comb begin
        w_any      = 1'b0;
        w_win_idx  = '0;
        w_win_prio = '0;
        for (int i = 0; i < N; i++) begin
            if (w_elig[i] && (r_prio[i] > w_win_prio)) begin
                w_any      = 1'b1;
                w_win_idx  = IDX_W'(i);
                w_win_prio = r_prio[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: SELECT may fall back to IDLE if a write removed the last candidate
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_any) w_state_nxt = c_SELECT;
            c_SELECT: w_state_nxt = w_any ? c_GRANT : c_IDLE;
            c_GRANT:  if (w_hs) w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // Grant outputs: captured in SELECT and frozen until the handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_grant_prio  <= '0;
        end else if (r_state == c_SELECT) begin
            if (w_any) begin
                r_grant_valid <= 1'b1;
                r_grant_idx   <= w_win_idx;
                r_grant_prio  <= w_win_prio;
            end
        end else if (w_hs) begin
            r_grant_valid <= 1'b0;
        end
    end

`ifdef PRIO_DISPATCH_STATS_EN
    logic [31:0] r_grant_count;
    logic [15:0] r_drop_count;
    logic [N-1:0] w_drop_bits;
    logic [16:0] w_drop_sum;

    // A drop is a request for a requester that is already pending and stays pending
    assign w_drop_bits = req & r_pending & ~w_clr;
    assign w_drop_sum  = {1'b0, r_drop_count} + 17'($countones(w_drop_bits));
    assign grant_count = r_grant_count;
    assign drop_count  = r_drop_count;

    // Statistics: wrapping grant counter, saturating drop counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant_count <= '0;
            r_drop_count  <= '0;
        end else begin
            if (w_hs) begin
                r_grant_count <= r_grant_count + 32'd1;
            end
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_prio_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_prio_dispatch
// Description : Self-checking bench for prio_dispatch: directed scenarios and
//               randomized rounds checked against a sorted-order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_dispatch;

    localparam int N      = 8;
    localparam int PRIO_W = 32;
    localparam int IDX_W  = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req = '0;
    logic              cfg_we = 1'b0;
    logic [IDX_W-1:0]  cfg_idx = '0;
    logic [PRIO_W-1:0] cfg_prio = '0;
    logic [N-1:0]      pending;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic [PRIO_W-1:0] grant_prio;
    logic              grant_ready = 1'b0;
`ifdef PRIO_DISPATCH_STATS_EN
    logic [31:0]       grant_count;
    logic [15:0]       drop_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [PRIO_W-1:0] m_prio [N];
    int                exp_q [$];

    prio_dispatch #(.N(N), .PRIO_W(PRIO_W), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_prio    (cfg_prio),
        .pending     (pending),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant_prio  (grant_prio),
        .grant_ready (grant_ready)
`ifdef PRIO_DISPATCH_STATS_EN
        ,
        .grant_count (grant_count),
        .drop_count  (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        req         = '0;
        cfg_we      = 1'b0;
        grant_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < N; i++) m_prio[i] = '0;
    endtask

    task automatic write_prio(input int idx, input logic [PRIO_W-1:0] val);
        cfg_we   = 1'b1;
        cfg_idx  = IDX_W'(idx);
        cfg_prio = val;
        m_prio[idx] = val;
        step();
        cfg_we = 1'b0;
    endtask

    // Steps until grant_valid is seen or the budget expires
    task automatic wait_valid(input int budget, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int k = 0; k < budget; k++) begin
            step();
            n++;
            if (grant_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Expected grant order: eligible requesters sorted by priority descending,
    // equal priorities kept in ascending index order
    task automatic build_expected(input logic [N-1:0] rq);
        int pos;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            if (rq[i] && m_prio[i] != '0) begin
                pos = 0;
                while (pos < exp_q.size() && m_prio[exp_q[pos]] >= m_prio[i]) pos++;
                exp_q.insert(pos, i);
            end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        checks++;
        if (grant_valid !== 1'b0 || pending !== 8'h00 || grant_idx !== 3'd0 || grant_prio !== 32'd0) begin
            errors++;
            $display("FAIL reset_assert: valid=%b pending=%h idx=%0d prio=%0d, expected all 0",
                     grant_valid, pending, grant_idx, grant_prio);
        end
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < N; i++) m_prio[i] = '0;
        step();
        step();
        checks++;
        if (grant_valid !== 1'b0 || pending !== 8'h00 || grant_idx !== 3'd0 || grant_prio !== 32'd0) begin
            errors++;
            $display("FAIL reset_release: valid=%b pending=%h idx=%0d prio=%0d, expected all 0",
                     grant_valid, pending, grant_idx, grant_prio);
        end
`ifdef PRIO_DISPATCH_STATS_EN
        checks++;
        if (grant_count !== 32'd0 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_stats: grant_count=%0d drop_count=%0d, expected 0 0", grant_count, drop_count);
        end
`endif
    endtask

    task automatic test_order();
        int pr [N] = '{7, 4, 3, 7, 5, 6, 7, 8};
        int ex [N] = '{7, 0, 3, 6, 5, 4, 1, 2};
        int n;
        bit ok;
        for (int i = 0; i < N; i++) write_prio(i, PRIO_W'(pr[i]));
        grant_ready = 1'b1;
        req = 8'hFF;
        step();
        req = '0;
        wait_valid(10, n, ok);
        checks++;
        if (!ok || n + 1 != 3) begin
            errors++;
            $display("FAIL order_latency: got %0d cycles (seen=%0b), expected 3", n + 1, ok);
        end
        for (int k = 0; k < N; k++) begin
            if (k > 0) begin
                wait_valid(10, n, ok);
                checks++;
                if (!ok || n != 3) begin
                    errors++;
                    $display("FAIL order_spacing[%0d]: got %0d cycles (seen=%0b), expected 3", k, n, ok);
                end
            end
            checks++;
            if (grant_idx !== IDX_W'(ex[k]) || grant_prio !== PRIO_W'(pr[ex[k]])) begin
                errors++;
                $display("FAIL order_grant[%0d]: idx=%0d prio=%0d, expected idx=%0d prio=%0d",
                         k, grant_idx, grant_prio, ex[k], pr[ex[k]]);
            end
        end
        step();
        step();
        checks++;
        if (pending !== 8'h00 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL order_drain: pending=%h valid=%b, expected 00 0", pending, grant_valid);
        end
`ifdef PRIO_DISPATCH_STATS_EN
        checks++;
        if (grant_count !== 32'd8) begin
            errors++;
            $display("FAIL order_grant_count: got %0d, expected 8", grant_count);
        end
`endif
        grant_ready = 1'b0;
    endtask

    task automatic test_zero_prio();
        int n;
        bit ok;
        bit seen;
        do_reset();
        grant_ready = 1'b1;
        req = 8'hFF;
        step();
        req = '0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (grant_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL zero_prio_no_grant: grant_valid rose, expected 0 for 20 cycles");
        end
        checks++;
        if (pending !== 8'hFF) begin
            errors++;
            $display("FAIL zero_prio_pending: got %h, expected ff", pending);
        end
        write_prio(5, 32'd1);
        wait_valid(10, n, ok);
        checks++;
        if (!ok || grant_idx !== 3'd5 || grant_prio !== 32'd1) begin
            errors++;
            $display("FAIL zero_prio_enable: seen=%0b idx=%0d prio=%0d, expected idx=5 prio=1",
                     ok, grant_idx, grant_prio);
        end
        step();
        checks++;
        if (pending !== 8'hDF) begin
            errors++;
            $display("FAIL zero_prio_clear: pending=%h, expected df", pending);
        end
        grant_ready = 1'b0;
    endtask

    task automatic test_no_preempt();
        int n;
        bit ok;
        bit stable;
        do_reset();
        write_prio(2, 32'd3);
        write_prio(7, 32'd8);
        req = 8'h04;
        step();
        req = '0;
        wait_valid(10, n, ok);
        checks++;
        if (!ok || grant_idx !== 3'd2 || grant_prio !== 32'd3) begin
            errors++;
            $display("FAIL nopre_first: seen=%0b idx=%0d prio=%0d, expected idx=2 prio=3",
                     ok, grant_idx, grant_prio);
        end
        req = 8'h80;
        step();
        req = '0;
        write_prio(2, 32'd9);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (grant_valid !== 1'b1 || grant_idx !== 3'd2 || grant_prio !== 32'd3) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL nopre_hold: valid=%b idx=%0d prio=%0d, expected 1 2 3 held",
                     grant_valid, grant_idx, grant_prio);
        end
        checks++;
        if (pending !== 8'h84) begin
            errors++;
            $display("FAIL nopre_pending: got %h, expected 84", pending);
        end
        grant_ready = 1'b1;
        wait_valid(10, n, ok);
        checks++;
        if (!ok || n != 3 || grant_idx !== 3'd7 || grant_prio !== 32'd8) begin
            errors++;
            $display("FAIL nopre_next: seen=%0b n=%0d idx=%0d prio=%0d, expected 3 cycles idx=7 prio=8",
                     ok, n, grant_idx, grant_prio);
        end
        step();
        grant_ready = 1'b0;
    endtask

    task automatic test_set_wins();
        int n;
        bit ok;
        do_reset();
        write_prio(4, 32'd5);
        req = 8'h10;
        step();
        req = '0;
        wait_valid(10, n, ok);
        checks++;
        if (!ok || grant_idx !== 3'd4) begin
            errors++;
            $display("FAIL setwin_first: seen=%0b idx=%0d, expected idx=4", ok, grant_idx);
        end
        grant_ready = 1'b1;
        req = 8'h10;
        step();
        req = '0;
        grant_ready = 1'b0;
        checks++;
        if (pending !== 8'h10 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL setwin_pending: pending=%h valid=%b, expected 10 0", pending, grant_valid);
        end
        wait_valid(10, n, ok);
        checks++;
        if (!ok || n != 2 || grant_idx !== 3'd4) begin
            errors++;
            $display("FAIL setwin_regrant: seen=%0b n=%0d idx=%0d, expected n=2 idx=4", ok, n, grant_idx);
        end
        grant_ready = 1'b1;
        step();
        grant_ready = 1'b0;
        checks++;
        if (pending !== 8'h00) begin
            errors++;
            $display("FAIL setwin_clear: pending=%h, expected 00", pending);
        end
    endtask

    task automatic test_abort_select();
        bit seen;
        do_reset();
        write_prio(3, 32'd2);
        req = 8'h08;
        step();
        req = '0;
        cfg_we   = 1'b1;
        cfg_idx  = 3'd3;
        cfg_prio = 32'd0;
        m_prio[3] = '0;
        step();
        cfg_we = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (grant_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_grant: grant_valid rose, expected 0");
        end
        checks++;
        if (pending !== 8'h08) begin
            errors++;
            $display("FAIL abort_pending: got %h, expected 08", pending);
        end
    endtask

    task automatic test_random();
        int n;
        bit ok;
        bit seen;
        int d;
        logic [N-1:0] rq;
        logic [N-1:0] left;
        for (int r = 0; r < 25; r++) begin
            do_reset();
            for (int i = 0; i < N; i++) write_prio(i, PRIO_W'($urandom_range(0, 5)));
            rq = N'($urandom_range(1, 255));
            left = '0;
            for (int i = 0; i < N; i++) if (rq[i] && m_prio[i] == '0) left[i] = 1'b1;
            build_expected(rq);
            req = rq;
            step();
            req = '0;
            foreach (exp_q[k]) begin
                wait_valid(12, n, ok);
                d = $urandom_range(0, 3);
                for (int j = 0; j < d; j++) step();
                checks++;
                if (!ok || grant_valid !== 1'b1 || grant_idx !== IDX_W'(exp_q[k]) ||
                    grant_prio !== m_prio[exp_q[k]]) begin
                    errors++;
                    $display("FAIL rand_grant r%0d[%0d]: valid=%b idx=%0d prio=%0d, expected idx=%0d prio=%0d",
                             r, k, grant_valid, grant_idx, grant_prio, exp_q[k], m_prio[exp_q[k]]);
                end
                grant_ready = 1'b1;
                step();
                grant_ready = 1'b0;
            end
            seen = 1'b0;
            for (int k = 0; k < 6; k++) begin
                step();
                if (grant_valid !== 1'b0) seen = 1'b1;
            end
            checks++;
            if (seen || pending !== left) begin
                errors++;
                $display("FAIL rand_drain r%0d: extra_grant=%0b pending=%h, expected 0 %h", r, seen, pending, left);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        do_reset();
        write_prio(1, 32'd4);
        req = 8'h83;
        step();
        req = '0;
        wait_valid(10, n, ok);
        checks++;
        if (!ok || grant_idx !== 3'd1) begin
            errors++;
            $display("FAIL rstmid_grant: seen=%0b idx=%0d, expected idx=1", ok, grant_idx);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (grant_valid !== 1'b0 || pending !== 8'h00 || grant_idx !== 3'd0 || grant_prio !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_clear: valid=%b pending=%h idx=%0d prio=%0d, expected all 0",
                     grant_valid, pending, grant_idx, grant_prio);
        end
        step();
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_order();
        test_zero_prio();
        test_no_preempt();
        test_set_wins();
        test_abort_select();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
